pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max MemWait cycles before error (1..255).
REQ-002 SHALL have ports: CLK  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: RST  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: Rs1D, Rs2D  in  5 each  decode-stage source regs.
REQ-005 SHALL have ports: Rs1E, Rs2E, RdE  in  5 each  execute-stage source/dest regs.
REQ-006 SHALL have ports: ResultSrcE  in  2  execute result select; 2'b01 = load.
REQ-007 SHALL have ports: RdM, RdW  in  5 each; RegWriteM, RegWriteW  in  1 each.
REQ-008 SHALL have ports: PCSrcE  in  1  taken branch/jump redirect.
REQ-009 SHALL have ports: MemReqM  in  1  load/store in M; MemReadyM  in  1  data-memory ack.
REQ-010 SHALL have ports: StallF, StallD, StallE, StallM  out  1 each  hold stage register.
REQ-011 SHALL have ports: FlushD, FlushE, FlushW  out  1 each  zero stage register (bubble).
REQ-012 SHALL have ports: ForwardAE, ForwardBE  out  2 each  EX operand select.
REQ-013 SHALL have ports: MemErr  out  1  sticky memory-timeout error.

Function
REQ-014 ForwardAE SHALL be 2'b10 if RegWriteM & RdM==Rs1E & Rs1E!=0, else 2'b01 if RegWriteW & RdW==Rs1E & Rs1E!=0, else 2'b00; ForwardBE same with Rs2E; M beats W.
REQ-015 lwStall SHALL be ResultSrcE==2'b01 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
REQ-016 In RUN with no memory wait: StallF=StallD=lwStall & ~PCSrcE; FlushD=PCSrcE; FlushE=lwStall | PCSrcE; StallE=StallM=FlushW=0.
REQ-017 memWait SHALL be MemReqM & ~MemReadyM, combinational, evaluated in RUN and MEM_WAIT.
REQ-018 While memWait: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0 (freeze overrides load-use and redirect; PCSrcE honoured after release).
REQ-019 FSM states SHALL be RUN, MEM_WAIT, ERROR.
REQ-020 RUN -> MEM_WAIT on edge with memWait; cycle counter loaded to 1.
REQ-021 MEM_WAIT -> RUN on edge with MemReadyM=1 (stalls drop combinationally that cycle); counter cleared.
REQ-022 MEM_WAIT: counter increments per cycle while memWait; on counter==MEM_TIMEOUT with memWait, -> ERROR.
REQ-023 ERROR SHALL be terminal until RST: all four stalls=1, FlushW=1, FlushD=FlushE=0, MemErr=1.
REQ-024 MemErr SHALL be registered, 0 in RUN/MEM_WAIT, 1 from first ERROR cycle.
REQ-025 Forwarding outputs SHALL be purely combinational in every state (no added latency).

Reset
REQ-026 RST high SHALL asynchronously force state RUN, counter 0, MemErr 0, perf counters 0.
REQ-027 While RST high: FlushD=FlushE=FlushW=1, all stalls 0, ForwardAE=ForwardBE=2'b00.
REQ-028 RST asserted mid-MEM_WAIT or in ERROR SHALL abandon the wait; first cycle after release is RUN.

Configuration
REQ-029 Macro HAZARD_PERF_EN defined: add outputs LdStallCnt, FlushCnt, MemWaitCnt (32 each), saturating at all-ones, counting lwStall-applied cycles, PCSrcE-flush cycles, memWait cycles.
REQ-030 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package hazard_pkg SHALL hold state enum (RUN, MEM_WAIT, ERROR), FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, RESULT_SRC_LOAD=2'b01.
REQ-032 Sub-module hazard_fwd_sel SHALL compute one operand select; instantiated twice (A, B).

Verification
REQ-033 Rs1E=5,RdM=5,RegWriteM=1,RdW=5,RegWriteW=1 -> ForwardAE=2'b10; Rs1E=0 same regs -> 2'b00.
REQ-034 ResultSrcE=01,RdE=7,Rs2D=7 -> StallF=StallD=FlushE=1 one cycle; add PCSrcE=1 -> StallF=StallD=0, FlushD=FlushE=1.
REQ-035 MemReqM=1,MemReadyM=0 for 3 cycles then 1 -> all stalls and FlushW high 3 cycles, RUN on 4th edge, MemErr=0.
REQ-036 MemReqM=1,MemReadyM=0 held, MEM_TIMEOUT=15 -> ERROR after 15 MEM_WAIT cycles, MemErr=1 persists after MemReadyM=1 until RST.
REQ-037 RST pulse mid-MEM_WAIT -> outputs per REQ-027 immediately (async), RUN after release.
REQ-038 With HAZARD_PERF_EN: 4 load-use stalls, 2 redirects, 5 wait cycles -> LdStallCnt=4, FlushCnt=2, MemWaitCnt=5.

Source files
------------

// File: rtl/hazard_pkg.sv
// Purpose : shared types and constants for the pipeline hazard controller.
// Latency : n/a (types, constants and one helper function only).
// Backpressure: n/a.
// Contents: hz_state_t (RUN, MEM_WAIT, ERROR), forwarding select codes,
//           load result-select code, saturating 32-bit increment helper.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } hz_state_t;

   // EX operand select codes
   localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
   localparam logic [1:0] FWD_WB  = 2'b01;  // result from writeback stage
   localparam logic [1:0] FWD_MEM = 2'b10;  // ALU result from memory stage

   // ResultSrcE encoding that marks a load in execute
   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Purpose : selects the bypass source for one EX-stage operand.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of the current register tags.
// Ports   : i_rs_e (EX source reg), i_rd_m/i_reg_write_m (M-stage writer),
//           i_rd_w/i_reg_write_w (W-stage writer), o_fwd (select code).
module hazard_fwd_sel (
   input  logic [4:0] i_rs_e,
   input  logic [4:0] i_rd_m,
   input  logic       i_reg_write_m,
   input  logic [4:0] i_rd_w,
   input  logic       i_reg_write_w,
   output logic [1:0] o_fwd
);
   import hazard_pkg::*;

   logic w_rs_nz;
   assign w_rs_nz = (i_rs_e != 5'd0);

   // M is checked first: it holds the younger write to the same register.
   always_comb begin
      o_fwd = FWD_RF;
      if (i_reg_write_m && (i_rd_m == i_rs_e) && w_rs_nz) begin
         o_fwd = FWD_MEM;
      end else if (i_reg_write_w && (i_rd_w == i_rs_e) && w_rs_nz) begin
         o_fwd = FWD_WB;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Purpose : 5-stage pipeline hazard unit: forwarding, load-use stall, branch
//           flush, data-memory wait freeze with timeout to a sticky error.
// Latency : stall/flush/forward outputs combinational; MemErr registered.
// Backpressure: MemReqM & ~MemReadyM freezes F/D/E/M and bubbles W until ack.
// Ports   : CLK, RST (async active-high); Rs1D/Rs2D; Rs1E/Rs2E/RdE/ResultSrcE;
//           RdM/RegWriteM/RdW/RegWriteW; PCSrcE; MemReqM/MemReadyM;
//           StallF/D/E/M, FlushD/E/W, ForwardAE/BE, MemErr.
//           Macro HAZARD_PERF_EN adds LdStallCnt, FlushCnt, MemWaitCnt.
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic [4:0] Rs1E,
   input  logic [4:0] Rs2E,
   input  logic [4:0] RdE,
   input  logic [1:0] ResultSrcE,
   input  logic [4:0] RdM,
   input  logic [4:0] RdW,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       PCSrcE,
   input  logic       MemReqM,
   input  logic       MemReadyM,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       StallM,
   output logic       FlushD,
   output logic       FlushE,
   output logic       FlushW,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       MemErr
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] LdStallCnt,
   output logic [31:0] FlushCnt,
   output logic [31:0] MemWaitCnt
`endif
);
   import hazard_pkg::*;

   localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

   hz_state_t  r_state;
   logic [7:0] r_wait_cnt;
   logic       r_mem_err;

   logic       w_mem_wait;
   logic       w_lw_stall;
   logic       w_in_error;
   logic       w_freeze;
   logic [1:0] w_fwd_a;
   logic [1:0] w_fwd_b;

   // ---------------------------------------------------------------
   // Forwarding
   // ---------------------------------------------------------------
   hazard_fwd_sel u_fwd_a (
      .i_rs_e        (Rs1E),
      .i_rd_m        (RdM),
      .i_reg_write_m (RegWriteM),
      .i_rd_w        (RdW),
      .i_reg_write_w (RegWriteW),
      .o_fwd         (w_fwd_a)
   );

   hazard_fwd_sel u_fwd_b (
      .i_rs_e        (Rs2E),
      .i_rd_m        (RdM),
      .i_reg_write_m (RegWriteM),
      .i_rd_w        (RdW),
      .i_reg_write_w (RegWriteW),
      .o_fwd         (w_fwd_b)
   );

   // ---------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------
   assign w_mem_wait = MemReqM & ~MemReadyM;
   assign w_lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));
   assign w_in_error = (r_state == ERROR);
   // A pending memory access only matters outside ERROR; ERROR freezes anyway.
   assign w_freeze   = w_in_error | w_mem_wait;

   // ---------------------------------------------------------------
   // Memory-wait FSM. The freeze itself is driven combinationally from
   // w_mem_wait so the pipeline holds on the very first cycle of a miss and
   // releases in the same cycle the ack arrives; the FSM only tracks how long
   // the wait has lasted and latches the error.
   // ---------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= RUN;
         r_wait_cnt <= 8'd0;
         r_mem_err  <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               if (w_mem_wait) begin
                  r_state    <= MEM_WAIT;
                  r_wait_cnt <= 8'd1;
               end
            end
            MEM_WAIT: begin
               if (!w_mem_wait) begin
                  r_state    <= RUN;
                  r_wait_cnt <= 8'd0;
               end else if (r_wait_cnt == TIMEOUT_C) begin
                  r_state   <= ERROR;
                  r_mem_err <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
            end
            ERROR: begin
               r_mem_err <= 1'b1;
            end
            default: begin
               r_state    <= RUN;
               r_wait_cnt <= 8'd0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Stall / flush outputs. Reset forces bubbles into every stage while
   // letting nothing hold, so the pipe drains to NOPs during reset.
   // ---------------------------------------------------------------
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (RST) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
         FlushW = 1'b1;
      end else if (w_freeze) begin
         // Freeze wins over load-use and redirect; a redirect held in E is
         // seen again once the pipe moves.
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else begin
         // A redirect squashes the dependent instruction, so no stall.
         StallF = w_lw_stall & ~PCSrcE;
         StallD = w_lw_stall & ~PCSrcE;
         FlushD = PCSrcE;
         FlushE = w_lw_stall | PCSrcE;
      end
   end

   assign ForwardAE = RST ? FWD_RF : w_fwd_a;
   assign ForwardBE = RST ? FWD_RF : w_fwd_b;
   assign MemErr    = r_mem_err;

`ifdef HAZARD_PERF_EN
   // ---------------------------------------------------------------
   // Performance counters (saturating)
   // ---------------------------------------------------------------
   logic [31:0] r_ld_stall_cnt;
   logic [31:0] r_flush_cnt;
   logic [31:0] r_mem_wait_cnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_ld_stall_cnt <= 32'd0;
         r_flush_cnt    <= 32'd0;
         r_mem_wait_cnt <= 32'd0;
      end else if (!w_in_error) begin
         if (w_mem_wait) begin
            r_mem_wait_cnt <= sat_inc32(r_mem_wait_cnt);
         end else begin
            if (w_lw_stall && !PCSrcE) begin
               r_ld_stall_cnt <= sat_inc32(r_ld_stall_cnt);
            end
            if (PCSrcE) begin
               r_flush_cnt <= sat_inc32(r_flush_cnt);
            end
         end
      end
   end

   assign LdStallCnt = r_ld_stall_cnt;
   assign FlushCnt   = r_flush_cnt;
   assign MemWaitCnt = r_mem_wait_cnt;
`endif

endmodule
